// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks: blank code, default
// scan rate and the width helper used to size counters and indices.
package seg_pkg;

    localparam logic [3:0] BLANK_CODE       = 4'hF;
    localparam int         SCAN_DIV_DEFAULT = 50000;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame-load and scan-output bundle between a frame source (master) and
// seg_scan_driver (slave).
interface seg_scan_driver_if #(
    parameter int DIGITS = 8
);
    localparam int IDX_W = (DIGITS > 1) ? seg_pkg::clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] bcd_in;
    logic                load;
    logic [3:0]          bcd_out;
    logic [DIGITS-1:0]   dig_sel;
    logic [IDX_W-1:0]    dig_idx;
    logic                frame_done;
    logic                pending;

    modport master (
        output bcd_in, load,
        input  bcd_out, dig_sel, dig_idx, frame_done, pending
    );

    modport slave (
        input  bcd_in, load,
        output bcd_out, dig_sel, dig_idx, frame_done, pending
    );

endinterface

// File: rtl/seg_scan_driver_prescaler.sv
// Modulo-DIV counter producing the one-cycle digit-slot tick.
module scan_prescaler
    import seg_pkg::*;
#(
    parameter int DIV = SCAN_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int              CNT_W = clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit 7-segment scanner with frame-boundary double buffering.
// Optional leading-zero blanking is enabled with LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int               IDX_W    = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int               FRAME_W  = 4 * DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic               tick;
    logic               boundary;
    logic [FRAME_W-1:0] shadow, shadow_next;
    logic [FRAME_W-1:0] display, display_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               pending, pending_next;
    logic               frame_done;
    logic [3:0]         bcd_out;
    logic [DIGITS-1:0]  dig_sel;

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    function automatic logic [3:0] digit_code(input logic [FRAME_W-1:0] frame,
                                              input logic [IDX_W-1:0]   k);
        logic [3:0] code;
        code = frame[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic upper_zero;
            upper_zero = 1'b1;
            for (int j = 0; j < DIGITS; j++) begin
                if (j >= int'(k) && frame[4*j +: 4] != 4'h0) upper_zero = 1'b0;
            end
            // Digit 0 always shows, so an all-zero frame reads "0".
            if (k != '0 && upper_zero) code = BLANK_CODE;
        end
`endif
        return code;
    endfunction

    function automatic logic [DIGITS-1:0] sel_code(input logic [IDX_W-1:0] k);
        logic [DIGITS-1:0] onehot;
        onehot    = '0;
        onehot[k] = 1'b1;
        return SEL_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    always_comb begin
        boundary     = tick && (idx == LAST_IDX);
        idx_next     = idx;
        shadow_next  = shadow;
        display_next = display;
        pending_next = pending;
        if (tick) idx_next = boundary ? '0 : idx + 1'b1;
        if (boundary) begin
            // A load landing on the boundary is the newest frame and bypasses the shadow.
            if (bus.load)     display_next = bus.bcd_in;
            else if (pending) display_next = shadow;
            pending_next = 1'b0;
        end else if (bus.load) begin
            shadow_next  = bus.bcd_in;
            pending_next = 1'b1;
        end
    end

    // Outputs are registered from the next-state values so select, code and index move together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            shadow     <= {DIGITS{BLANK_CODE}};
            display    <= {DIGITS{BLANK_CODE}};
            pending    <= 1'b0;
            frame_done <= 1'b0;
            bcd_out    <= BLANK_CODE;
            dig_sel    <= sel_code('0);
        end else begin
            idx        <= idx_next;
            shadow     <= shadow_next;
            display    <= display_next;
            pending    <= pending_next;
            frame_done <= boundary;
            bcd_out    <= digit_code(display_next, idx_next);
            dig_sel    <= sel_code(idx_next);
        end
    end

    assign bus.bcd_out    = bcd_out;
    assign bus.dig_sel    = dig_sel;
    assign bus.dig_idx    = idx;
    assign bus.frame_done = frame_done;
    assign bus.pending    = pending;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (DIGITS=4, SCAN_DIV=4, active-low select).
module tb_seg_scan_driver;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    seg_scan_driver_if #(.DIGITS(4)) bus ();

    seg_scan_driver #(
        .DIGITS         (4),
        .SCAN_DIV       (4),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps at least one cycle, then stops on the cycle where frame_done is high.
    task automatic seek_boundary(output bit found);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_done !== 1'b1 && n < 64);
        found = (bus.frame_done === 1'b1);
    endtask

    task automatic load_frame(input logic [15:0] data);
        bus.bcd_in = data;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        int gap;
        checks++;
        if (bus.bcd_out !== 4'hF || bus.dig_sel !== 4'b1110 || bus.dig_idx !== 2'd0 ||
            bus.pending !== 1'b0 || bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: bcd_out=%h dig_sel=%b dig_idx=%0d pending=%b frame_done=%b, required F 1110 0 0 0",
                     bus.bcd_out, bus.dig_sel, bus.dig_idx, bus.pending, bus.frame_done);
        end
        rst_n = 1'b1;
        seek_boundary(found);
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL reset_first_boundary: frame_done never seen, required a pulse");
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== 4'hF || bus.dig_idx !== 2'(k)) begin
                fails++;
                $display("FAIL reset_blank_slot%0d: bcd_out=%h dig_idx=%0d, required F %0d",
                         k, bus.bcd_out, bus.dig_idx, k);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
        // Measure the distance from the next pulse to the one after it.
        seek_boundary(found);
        @(negedge clk);
        checks++;
        if (bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL frame_done_width: frame_done=%b one cycle after pulse, required 0", bus.frame_done);
        end
        gap = 1;
        while (bus.frame_done !== 1'b1 && gap < 64) begin
            @(negedge clk);
            gap++;
        end
        checks++;
        if (gap != 16) begin
            fails++;
            $display("FAIL frame_done_period: %0d clks, required 16", gap);
        end
    endtask

    task automatic test_load_mid_frame();
        bit found;
        logic [3:0] exp_sel;
        logic [15:0] exp;
        exp = 16'h1234;
        seek_boundary(found);
        repeat (5) @(negedge clk);
        load_frame(16'h1234);
        checks++;
        if (bus.pending !== 1'b1) begin
            fails++;
            $display("FAIL load_pending_set: pending=%b, required 1", bus.pending);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (bus.pending !== 1'b1 || bus.bcd_out !== 4'hF) begin
            fails++;
            $display("FAIL load_held_until_boundary: pending=%b bcd_out=%h, required 1 F",
                     bus.pending, bus.bcd_out);
        end
        seek_boundary(found);
        checks++;
        if (!found || bus.pending !== 1'b0) begin
            fails++;
            $display("FAIL load_pending_clear: found=%b pending=%b, required 1 0", found, bus.pending);
        end
        for (int k = 0; k < 4; k++) begin
            exp_sel = ~(4'b0001 << k);
            checks++;
            if (bus.bcd_out !== exp[4*k +: 4] || bus.dig_sel !== exp_sel || bus.dig_idx !== 2'(k)) begin
                fails++;
                $display("FAIL load_1234_slot%0d: bcd_out=%h dig_sel=%b dig_idx=%0d, required %h %b %0d",
                         k, bus.bcd_out, bus.dig_sel, bus.dig_idx, exp[4*k +: 4], exp_sel, k);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_last_load_wins();
        bit found;
        logic [15:0] exp;
        exp = 16'h5678;
        seek_boundary(found);
        repeat (2) @(negedge clk);
        load_frame(16'h1111);
        repeat (3) @(negedge clk);
        load_frame(16'h5678);
        seek_boundary(found);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== exp[4*k +: 4] || bus.dig_idx !== 2'(k)) begin
                fails++;
                $display("FAIL last_load_slot%0d: bcd_out=%h dig_idx=%0d, required %h %0d",
                         k, bus.bcd_out, bus.dig_idx, exp[4*k +: 4], k);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_load_at_boundary();
        bit found;
        logic [15:0] exp;
        exp = 16'hABC9;
        seek_boundary(found);
        repeat (15) @(negedge clk);
        checks++;
        if (bus.dig_idx !== 2'd3 || bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL boundary_position: dig_idx=%0d frame_done=%b, required 3 0",
                     bus.dig_idx, bus.frame_done);
        end
        load_frame(16'hABC9);
        checks++;
        if (bus.frame_done !== 1'b1 || bus.pending !== 1'b0 || bus.dig_idx !== 2'd0) begin
            fails++;
            $display("FAIL boundary_load_direct: frame_done=%b pending=%b dig_idx=%0d, required 1 0 0",
                     bus.frame_done, bus.pending, bus.dig_idx);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== exp[4*k +: 4] || bus.pending !== 1'b0) begin
                fails++;
                $display("FAIL boundary_load_slot%0d: bcd_out=%h pending=%b, required %h 0",
                         k, bus.bcd_out, bus.pending, exp[4*k +: 4]);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_leading_zero();
        bit found;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
`ifdef LEADING_ZERO_BLANK_EN
        exp_a = 16'hFF70;
        exp_b = 16'hFFF0;
`else
        exp_a = 16'h0070;
        exp_b = 16'h0000;
`endif
        seek_boundary(found);
        repeat (3) @(negedge clk);
        load_frame(16'h0070);
        seek_boundary(found);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== exp_a[4*k +: 4]) begin
                fails++;
                $display("FAIL lzb_0070_slot%0d: bcd_out=%h, required %h", k, bus.bcd_out, exp_a[4*k +: 4]);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
        seek_boundary(found);
        repeat (3) @(negedge clk);
        load_frame(16'h0000);
        seek_boundary(found);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== exp_b[4*k +: 4]) begin
                fails++;
                $display("FAIL lzb_0000_slot%0d: bcd_out=%h, required %h", k, bus.bcd_out, exp_b[4*k +: 4]);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        seek_boundary(found);
        repeat (3) @(negedge clk);
        load_frame(16'h4321);
        checks++;
        if (bus.pending !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pending_before: pending=%b, required 1", bus.pending);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bcd_out !== 4'hF || bus.dig_sel !== 4'b1110 || bus.dig_idx !== 2'd0 ||
            bus.pending !== 1'b0 || bus.frame_done !== 1'b0) begin
            fails++;
            $display("FAIL midreset_state: bcd_out=%h dig_sel=%b dig_idx=%0d pending=%b frame_done=%b, required F 1110 0 0 0",
                     bus.bcd_out, bus.dig_sel, bus.dig_idx, bus.pending, bus.frame_done);
        end
        rst_n = 1'b1;
        seek_boundary(found);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.bcd_out !== 4'hF || bus.dig_idx !== 2'(k)) begin
                fails++;
                $display("FAIL midreset_discard_slot%0d: bcd_out=%h dig_idx=%0d, required F %0d",
                         k, bus.bcd_out, bus.dig_idx, k);
            end
            if (k < 3) repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bus.load   = 1'b0;
        bus.bcd_in = 16'h0000;
        repeat (3) @(negedge clk);
        test_reset();
        test_load_mid_frame();
        test_last_load_wins();
        test_load_at_boundary();
        test_leading_zero();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
